demux1x2_tdm: RTL and testbench
===============================

# demux1x2_tdm

Two-channel time-division demultiplexer: the receive-side counterpart of the gate-level 2:1 mux with a toggling select. It takes a single interleaved data stream (slot 0 marked by `sync`, slot 1 following) and separates it into two registered channel outputs. It tracks frame alignment and drops stray beats until re-aligned. It sits at the far end of a select-multiplexed link and feeds per-channel consumers.

## Interface
- `WIDTH`, 8: data width of each slot.
- `ERRW`, 8: width of the saturating sync-error counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  WIDTH  interleaved slot data.
- `din_valid`  in  1  `din` carries a slot this cycle.
- `sync`  in  1  qualifies `din` as slot 0 (channel 0); ignored when `din_valid`=0.
- `y0`  out  WIDTH  last captured channel-0 data, held.
- `y1`  out  WIDTH  last captured channel-1 data, held.
- `y0_valid`  out  1  one-cycle pulse: `y0` updated.
- `y1_valid`  out  1  one-cycle pulse: `y1` updated.
- `pair_valid`  out  1  one-cycle pulse: `y0`/`y1` hold a complete aligned frame.
- `s`  out  1  slot expected next (0 = channel 0, 1 = channel 1).
- `locked`  out  1  frame alignment established.
- `sync_err`  out  1  one-cycle pulse on an alignment violation.
- `err_cnt`  out  ERRW  saturating count of `sync_err` pulses.

## Operation
- FSM states: HUNT, EXP1 (ch0 captured, expecting ch1), EXP0 (frame complete, expecting ch0).
- Idle cycles (`din_valid`=0) change no state and produce no pulses in any state.
- HUNT:
  - `din_valid`&`sync` -> capture `y0`, pulse `y0_valid`, go EXP1.
  - `din_valid`&!`sync` -> beat discarded, no pulse, stay HUNT.
- EXP1:
  - `din_valid`&!`sync` -> capture `y1`, pulse `y1_valid` and `pair_valid`, go EXP0.
  - `din_valid`&`sync` (ch1 missing) -> pulse `sync_err`; treat the beat as a new ch0: capture `y0`, pulse `y0_valid`, stay EXP1. No `pair_valid`.
- EXP0:
  - `din_valid`&`sync` -> capture `y0`, pulse `y0_valid`, go EXP1.
  - `din_valid`&!`sync` (extra slot) -> pulse `sync_err`, discard beat, go HUNT.
- `s` = 1 in EXP1, else 0.
- `locked` = 1 in EXP1 or EXP0, 0 in HUNT.
- `err_cnt` increments on every `sync_err` and saturates at 2^ERRW-1; it never wraps.
- `y0`/`y1` change only on capture.
- Between a ch0 capture and the matching ch1 capture, `y1` still holds the previous frame. Consumers sample only on `pair_valid`.

## Timing
- All outputs are registered. A beat presented in cycle N is visible on `y0`/`y1` and the pulses in cycle N+1: latency 1, throughput one slot per cycle. Back-to-back beats are supported with no bubbles.
- Pulses are high for exactly one cycle per qualifying beat.
- `pair_valid` is coincident with `y1_valid`. At that edge `y0` holds the ch0 of the same frame.
- Reset (asserted at any time, including mid-frame) immediately forces:
  - state HUNT
  - `y0`=`y1`=0, `err_cnt`=0
  - all pulses 0, `s`=0, `locked`=0.
- The first beat after reset deassertion is evaluated normally. A partially received frame is discarded and its ch0 is never paired.
- Simultaneous saturation and error: `sync_err` still pulses and `err_cnt` holds at max.

## Test plan
- Reset, then beats (0xA5,sync=1),(0x3C,sync=0) on consecutive cycles -> cycle+1: `y0`=0xA5, `y0_valid`; cycle+2: `y1`=0x3C, `y1_valid`=`pair_valid`=1, `locked`=1, `s`=0.
- From HUNT, send 0x11,0x22 with sync=0, then 0x33/sync=1, 0x44/sync=0 -> first two dropped with no pulses, `locked`=0. Then `pair_valid` with `y0`=0x33, `y1`=0x44.
- Locked in EXP1, send 0x55/sync=1 -> `sync_err`=1, `err_cnt`=1, `y0`=0x55, no `pair_valid`, `s` stays 1.
- Locked in EXP0, send 0x66/sync=0 -> `sync_err`=1, `locked`=0 next cycle, `y0`/`y1` unchanged, state HUNT.
- Continuous alternating stream of 8 frames with idle gaps inserted between slots -> 8 `pair_valid` pulses, each with the correct pair, and idle cycles produce no pulses. Then force 300 errors with ERRW=8 -> `err_cnt`=255.
- Assert `rst` in EXP1 after a ch0 of 0x77 -> all outputs 0 immediately. After release, ch1-only beat 0x88/sync=0 -> dropped, no `pair_valid`.

Source files
------------

// File: rtl/demux1x2_tdm.sv
// Two-channel TDM demultiplexer: splits a sync-marked interleaved stream into
// two registered channel outputs, tracking frame alignment and counting violations.
module demux1x2_tdm #(
    parameter int WIDTH = 8,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             y0_valid,
    output logic             y1_valid,
    output logic             pair_valid,
    output logic             s,
    output logic             locked,
    output logic             sync_err,
    output logic [ERRW-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        EXP1 = 2'd1,
        EXP0 = 2'd2
    } state_t;

    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic             cap0_s;
    logic             cap1_s;
    logic             err_s;
    logic [WIDTH-1:0] y0_r;
    logic [WIDTH-1:0] y1_r;
    logic             y0_valid_r;
    logic             y1_valid_r;
    logic             pair_valid_r;
    logic             s_r;
    logic             locked_r;
    logic             sync_err_r;
    logic [ERRW-1:0]  err_cnt_r;

    // Next-state and capture decisions for the current beat
    always_comb begin
        state_nxt_s = state_r;
        cap0_s      = 1'b0;
        cap1_s      = 1'b0;
        err_s       = 1'b0;
        if (din_valid) begin
            case (state_r)
                HUNT: begin
                    if (sync) begin
                        cap0_s      = 1'b1;
                        state_nxt_s = EXP1;
                    end else begin
                        state_nxt_s = HUNT;
                    end
                end
                EXP1: begin
                    if (sync) begin
                        // ch1 went missing: restart the frame on this beat
                        err_s       = 1'b1;
                        cap0_s      = 1'b1;
                        state_nxt_s = EXP1;
                    end else begin
                        cap1_s      = 1'b1;
                        state_nxt_s = EXP0;
                    end
                end
                EXP0: begin
                    if (sync) begin
                        cap0_s      = 1'b1;
                        state_nxt_s = EXP1;
                    end else begin
                        err_s       = 1'b1;
                        state_nxt_s = HUNT;
                    end
                end
                default: begin
                    state_nxt_s = HUNT;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, data capture, pulse and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= HUNT;
            y0_r         <= {WIDTH{1'b0}};
            y1_r         <= {WIDTH{1'b0}};
            y0_valid_r   <= 1'b0;
            y1_valid_r   <= 1'b0;
            pair_valid_r <= 1'b0;
            s_r          <= 1'b0;
            locked_r     <= 1'b0;
            sync_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            y0_valid_r   <= cap0_s;
            y1_valid_r   <= cap1_s;
            pair_valid_r <= cap1_s;
            sync_err_r   <= err_s;
            s_r          <= (state_nxt_s == EXP1);
            locked_r     <= (state_nxt_s != HUNT);
            if (cap0_s) begin
                y0_r <= din;
            end
            if (cap1_s) begin
                y1_r <= din;
            end
        end
    end

    // Saturating violation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= {ERRW{1'b0}};
        end else if (err_s && (err_cnt_r != ERR_MAX)) begin
            err_cnt_r <= err_cnt_r + {{(ERRW-1){1'b0}}, 1'b1};
        end
    end

    assign y0         = y0_r;
    assign y1         = y1_r;
    assign y0_valid   = y0_valid_r;
    assign y1_valid   = y1_valid_r;
    assign pair_valid = pair_valid_r;
    assign s          = s_r;
    assign locked     = locked_r;
    assign sync_err   = sync_err_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_demux1x2_tdm.sv
// Bench for demux1x2_tdm: directed beats, an event-level reference model
// compared every cycle, and hand-computed literal checks.
module tb_demux1x2_tdm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] y0, y1, err_cnt;
    logic       y0_valid, y1_valid, pair_valid, s, locked, sync_err;

    int n_tests = 0;
    int n_fail  = 0;
    int pair_seen = 0;

    demux1x2_tdm #(.WIDTH(8), .ERRW(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
        .y0(y0), .y1(y1), .y0_valid(y0_valid), .y1_valid(y1_valid),
        .pair_valid(pair_valid), .s(s), .locked(locked),
        .sync_err(sync_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is "open" once ch0 has arrived, "aligned" once any ch0 seen
    logic [7:0] m_y0, m_y1;
    logic       m_v0, m_v1, m_pair, m_err;
    int         m_cnt;
    bit         m_open, m_aligned;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_y0 = 8'h00; m_y1 = 8'h00; m_v0 = 1'b0; m_v1 = 1'b0;
            m_pair = 1'b0; m_err = 1'b0; m_cnt = 0; m_open = 0; m_aligned = 0;
        end else begin
            m_v0 = 1'b0; m_v1 = 1'b0; m_pair = 1'b0; m_err = 1'b0;
            if (din_valid && sync) begin
                if (m_open) m_err = 1'b1;
                m_y0 = din; m_v0 = 1'b1; m_open = 1; m_aligned = 1;
            end else if (din_valid) begin
                if (m_open) begin
                    m_y1 = din; m_v1 = 1'b1; m_pair = 1'b1; m_open = 0;
                end else if (m_aligned) begin
                    m_err = 1'b1; m_aligned = 0;
                end
            end
            if (m_err && m_cnt < 255) m_cnt++;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("y0", y0, m_y0);
        chk("y1", y1, m_y1);
        chk("y0_valid", y0_valid, m_v0);
        chk("y1_valid", y1_valid, m_v1);
        chk("pair_valid", pair_valid, m_pair);
        chk("sync_err", sync_err, m_err);
        chk("err_cnt", err_cnt, m_cnt);
        chk("s", s, m_open);
        chk("locked", locked, m_aligned);
        if (pair_valid) pair_seen++;
    end

    task automatic send(input logic [7:0] d, input logic sy);
        din = d; din_valid = 1'b1; sync = sy;
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic idle();
        din_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int base;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_y0", y0, 8'h00);
        chk("rst_locked", locked, 1'b0);
        chk("rst_cnt", err_cnt, 8'h00);

        // Basic aligned frame
        send(8'hA5, 1'b1);
        chk("t1_y0", y0, 8'hA5);
        chk("t1_v0", y0_valid, 1'b1);
        chk("t1_s", s, 1'b1);
        send(8'h3C, 1'b0);
        chk("t1_y1", y1, 8'h3C);
        chk("t1_pair", pair_valid, 1'b1);
        chk("t1_v1", y1_valid, 1'b1);
        chk("t1_locked", locked, 1'b1);
        chk("t1_s0", s, 1'b0);
        idle();
        chk("t1_idle_pair", pair_valid, 1'b0);

        // Hunting drops stray beats
        do_reset();
        send(8'h11, 1'b0);
        chk("t2_drop_v0", y0_valid, 1'b0);
        chk("t2_drop_locked", locked, 1'b0);
        send(8'h22, 1'b0);
        chk("t2_drop_v1", y1_valid, 1'b0);
        send(8'h33, 1'b1);
        send(8'h44, 1'b0);
        chk("t2_pair", pair_valid, 1'b1);
        chk("t2_y0", y0, 8'h33);
        chk("t2_y1", y1, 8'h44);

        // Missing ch1 while expecting it
        send(8'h12, 1'b1);
        send(8'h55, 1'b1);
        chk("t3_err", sync_err, 1'b1);
        chk("t3_cnt", err_cnt, 8'd1);
        chk("t3_y0", y0, 8'h55);
        chk("t3_pair", pair_valid, 1'b0);
        chk("t3_s", s, 1'b1);

        // Extra slot after a complete frame
        send(8'h56, 1'b0);
        send(8'h66, 1'b0);
        chk("t4_err", sync_err, 1'b1);
        chk("t4_locked", locked, 1'b0);
        chk("t4_y0", y0, 8'h55);
        chk("t4_y1", y1, 8'h56);
        chk("t4_cnt", err_cnt, 8'd2);

        // Eight frames with idle gaps
        base = pair_seen;
        for (int i = 0; i < 8; i++) begin
            send(8'h80 + 8'(i), 1'b1);
            idle();
            send(8'h90 + 8'(i), 1'b0);
            chk("t5_pair", pair_valid, 1'b1);
            chk("t5_y0", y0, 8'h80 + 8'(i));
            chk("t5_y1", y1, 8'h90 + 8'(i));
            idle();
        end
        chk("t5_pairs", pair_seen - base, 8);

        // Saturation: 300 consecutive ch1-missing errors
        send(8'h00, 1'b1);
        for (int i = 0; i < 300; i++) send(8'(i), 1'b1);
        chk("t5_sat_cnt", err_cnt, 8'd255);
        chk("t5_sat_err", sync_err, 1'b1);
        idle();

        // Asynchronous reset mid-frame
        send(8'h77, 1'b1);
        chk("t6_pre_y0", y0, 8'h77);
        #2 rst = 1'b1;
        #1;
        chk("t6_y0", y0, 8'h00);
        chk("t6_y1", y1, 8'h00);
        chk("t6_cnt", err_cnt, 8'h00);
        chk("t6_locked", locked, 1'b0);
        chk("t6_s", s, 1'b0);
        chk("t6_v0", y0_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'h88, 1'b0);
        chk("t6_pair", pair_valid, 1'b0);
        chk("t6_v1", y1_valid, 1'b0);
        chk("t6_y1_after", y1, 8'h00);
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
